// File: rtl/count_seq_pkg.sv
// Shared types and helpers for the count4 sequencing controller.
// Holds the FSM state encoding, the legal count4 states and its successor function.
package count_seq_pkg;

  localparam int WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // The eight states count4 cycles through, in sequence order from 0000.
  localparam logic [8*WIDTH-1:0] LEGAL_STATES = {
    4'b1110, 4'b0101, 4'b0010, 4'b1111,
    4'b0001, 4'b1010, 4'b1101, 4'b0000
  };

  function automatic logic [WIDTH-1:0] succ(input logic [WIDTH-1:0] q);
    return {~q[1], ~q[3], q[0], ~q[2]};
  endfunction

  function automatic logic is_legal(input logic [WIDTH-1:0] q);
    logic w_hit;
    w_hit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (q == LEGAL_STATES[i*WIDTH +: WIDTH]) w_hit = 1'b1;
    end
    return w_hit;
  endfunction

endpackage

// File: rtl/count_seq_chk.sv
// Combinational count4 checker: flags an illegal state, or a state that differs
// from the expected one in the cycle right after a step or clear.
module count_seq_chk
  import count_seq_pkg::*;
(
  input  logic [WIDTH-1:0] i_cnt_q,
  input  logic [WIDTH-1:0] i_exp,
  input  logic             i_exp_vld,
  output logic             o_err_set
);

  logic w_illegal;
  logic w_mismatch;

  assign w_illegal  = !is_legal(i_cnt_q);
  assign w_mismatch = i_exp_vld && (i_cnt_q != i_exp);
  assign o_err_set  = w_illegal || w_mismatch;

endmodule

// File: rtl/count_seq_ctrl.sv
// Runs an enable-gated count4 for N accepted steps with optional pre-clear,
// pause and abort; every step is checked against the expected successor.
module count_seq_ctrl #(
  parameter int WIDTH = count_seq_pkg::WIDTH,
  parameter int CW    = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [CW-1:0]    req_steps,
  input  logic             req_clear,
  input  logic             pause,
  input  logic             abort,
  input  logic [WIDTH-1:0] cnt_q,
  output logic             cnt_en,
  output logic             cnt_clr,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CW-1:0]    steps_left
);
  import count_seq_pkg::*;

  state_t           r_state;
  logic [CW-1:0]    r_steps_left;
  logic [WIDTH-1:0] r_exp;
  logic             r_exp_vld;
  logic             r_err;
  logic             w_err_set;

  count_seq_chk u_chk (
    .i_cnt_q   (cnt_q),
    .i_exp     (r_exp),
    .i_exp_vld (r_exp_vld),
    .o_err_set (w_err_set)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state      <= ST_IDLE;
      r_steps_left <= '0;
      r_exp        <= '0;
      r_exp_vld    <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      // Each expectation is checked exactly once, in the cycle after it is loaded.
      r_exp_vld <= 1'b0;
      if (w_err_set) r_err <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_steps_left <= req_steps;
            if (req_steps == '0)  r_state <= ST_DONE;
            else if (req_clear)   r_state <= ST_CLEAR;
            else                  r_state <= ST_RUN;
          end
        end
        ST_CLEAR: begin
          if (abort) begin
            r_state      <= ST_IDLE;
            r_steps_left <= '0;
          end else begin
            r_exp     <= '0;
            r_exp_vld <= 1'b1;
            r_state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort) begin
            r_state      <= ST_IDLE;
            r_steps_left <= '0;
          end else if (!pause) begin
            if (r_steps_left != '0) r_steps_left <= r_steps_left - CW'(1);
            r_exp     <= succ(cnt_q);
            r_exp_vld <= 1'b1;
            if (r_steps_left == CW'(1)) r_state <= ST_DONE;
          end
        end
        ST_DONE:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign busy       = (r_state != ST_IDLE);
  assign cnt_clr    = (r_state == ST_CLEAR);
  assign done       = (r_state == ST_DONE);
  assign cnt_en     = (r_state == ST_RUN) && !pause && !abort;
  assign err        = r_err;
  assign steps_left = r_steps_left;

endmodule
